countdown_core: RTL and testbench
=================================

# countdown_core

Countdown engine for the egg timer, downstream of the controller FSM. It holds the MM:SS time as four BCD digits and decrements it once per second while the controller is in its TIMER state. It raises a one-cycle `done` strobe when the time reaches 00:00, which moves the controller to its flash states. The digit outputs drive the four `dec2_7seg` displays directly.

## Interface
Parameters:
- `CLK_HZ`, 50000000: clock cycles per one-second tick.
- `FLASH_DIV`, 12500000: cycles per half-period of `flash`; used only with `COUNTDOWN_FLASH_EN`.

Ports:
- `CLOCK_50` in 1: the single clock; all state updates on its rising edge.
- `RST` in 1: reset, asynchronous and active-high.
- `load` in 1: capture the load digits; has priority over `run`.
- `ld_min_hi`, `ld_min_lo`, `ld_sec_hi`, `ld_sec_lo` in 4 each: BCD load values.
- `run` in 1: level; counting enabled while high.
- `min_hi`, `min_lo`, `sec_hi`, `sec_lo` out 4 each: current BCD digits.
- `zero` out 1: high when all four digits are 0.
- `tick` out 1: one-cycle strobe on each one-second decrement.
- `done` out 1: one-cycle strobe when the count expires.
- `flash` out 1: expiry blink.

## Operation
- States:
  - IDLE (reset state): holding time, prescaler frozen.
  - RUN: counting.
  - EXPIRED: count is 00:00 after counting down.
- Transitions:
  - IDLE→RUN when `run`=1 and `zero`=0.
  - IDLE with `run`=1 and `zero`=1 stays in IDLE; no `done`.
  - RUN→IDLE when `run`=0 (pause). Digits and prescaler are held, so a resume continues the partial second.
  - RUN→EXPIRED on the decrement that produces 00:00.
  - EXPIRED→IDLE only on `load`. `run` is ignored in EXPIRED.
  - `load` in any state: go to IDLE, capture digits, clear prescaler.
- Load sanitising:
  - Any digit >9 loads as 9.
  - `ld_sec_hi` >5 loads as 5.
  - Example: load 9F:7A displays 99:59.
- Prescaler: counts 0..`CLK_HZ`-1 in RUN only. At `CLK_HZ`-1 it wraps to 0 and issues `tick`.
- Decrement with borrow chain:
  - `sec_lo` 0→9 borrows from `sec_hi`.
  - `sec_hi` 0→5 borrows from `min_lo`.
  - `min_lo` 0→9 borrows from `min_hi`.
  - From 00:00 no decrement occurs; this is unreachable in RUN.
- Maximum count is 99:59; there is no hours wrap.
- `zero` is combinational from the digit registers.

## Timing
- Reset values:
  - State IDLE, prescaler 0.
  - All digits 0, so `zero`=1.
  - `tick`=0, `done`=0, `flash`=0.
- `load` sampled at edge N: digits valid after edge N. There is one cycle of latency.
- `tick`: high during the cycle in which prescaler = `CLK_HZ`-1 in RUN. The digits decrement on the edge ending that cycle.
- First tick after entering RUN from a fresh load: exactly `CLK_HZ` cycles after the edge on which the state became RUN.
- `done`: registered. It is high for exactly one cycle, the cycle after the edge that wrote 00:00 and entered EXPIRED.
- `load` and the final tick in the same cycle: `load` wins. No `done`; the state becomes IDLE with the loaded value.
- `run` falling in the tick cycle: the tick still applies. The state becomes IDLE after that edge.
- `RST` mid-count: immediate asynchronous clear to the reset values. No `done` is produced.

## Configuration
- `COUNTDOWN_FLASH_EN` defined:
  - In EXPIRED, a divider toggles `flash` every `FLASH_DIV` cycles.
  - The divider starts at 0 with `flash`=1 on entry to EXPIRED.
  - Leaving EXPIRED forces `flash`=0 and clears the divider.
- `COUNTDOWN_FLASH_EN` undefined:
  - No divider logic; `flash` is tied to 0.
  - The controller's own blink is used instead.

## Test plan
Bench uses `CLK_HZ`=4, `FLASH_DIV`=2.
1. Load 00:03, then run: `tick` at cycles 4, 8, 12 after RUN entry. Digits show 00:02, 00:01, 00:00. `done` pulses once at cycle 13; `zero`=1.
2. Load 10:00, run one tick: 09:59, which exercises the full borrow chain. Load 9F:7A: reads 99:59.
3. Load 00:05, run 6 cycles, drop `run` for 10 cycles, raise it: the next tick arrives 2 cycles after resume. Digits hold 00:04 during the pause.
4. Load 00:01, assert `load` of 00:30 in the tick cycle: digits 00:30, state IDLE, no `done`.
5. Load 00:00, hold `run`=1 for 20 cycles: no `tick`, no `done`, digits stay 00:00.
6. In RUN at 00:02, assert `RST` between edges: all outputs clear immediately. With `COUNTDOWN_FLASH_EN`, a separate run to expiry shows `flash` toggling every 2 cycles until `load`.

Source files
------------

// File: rtl/countdown_core.sv
// Egg-timer countdown engine: four BCD digits (MM:SS) decremented once per CLK_HZ cycles.
// Optional expiry blink divider enabled by defining COUNTDOWN_FLASH_EN.

module countdown_core #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned FLASH_DIV = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       load,
  input  logic [3:0] ld_min_hi,
  input  logic [3:0] ld_min_lo,
  input  logic [3:0] ld_sec_hi,
  input  logic [3:0] ld_sec_lo,
  input  logic       run,
  output logic [3:0] min_hi,
  output logic [3:0] min_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] sec_lo,
  output logic       zero,
  output logic       tick,
  output logic       done,
  output logic       flash
);

  // state     | meaning
  // S_IDLE    | holding time, prescaler frozen (reset state)
  // S_RUN     | counting, one decrement per CLK_HZ cycles
  // S_EXPIRED | reached 00:00 while counting; only load leaves

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc_rem;   // cycles remaining until the next tick
  logic [3:0]    nxt_min_hi;
  logic [3:0]    nxt_min_lo;
  logic [3:0]    nxt_sec_hi;
  logic [3:0]    nxt_sec_lo;
  logic          last_sec;
  logic          enter_exp;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  assign zero      = (min_hi == 4'd0) && (min_lo == 4'd0) && (sec_hi == 4'd0) && (sec_lo == 4'd0);
  assign last_sec  = (min_hi == 4'd0) && (min_lo == 4'd0) && (sec_hi == 4'd0) && (sec_lo == 4'd1);
  assign tick      = (state == S_RUN) && (presc_rem == '0);
  assign enter_exp = tick && last_sec && !load;

  // Borrow chain; 00:00 is left untouched rather than wrapping to 99:59.
  always_comb begin
    nxt_min_hi = min_hi;
    nxt_min_lo = min_lo;
    nxt_sec_hi = sec_hi;
    nxt_sec_lo = sec_lo;
    if (!zero) begin
      if (sec_lo != 4'd0) begin
        nxt_sec_lo = sec_lo - 4'd1;
      end else begin
        nxt_sec_lo = 4'd9;
        if (sec_hi != 4'd0) begin
          nxt_sec_hi = sec_hi - 4'd1;
        end else begin
          nxt_sec_hi = 4'd5;
          if (min_lo != 4'd0) begin
            nxt_min_lo = min_lo - 4'd1;
          end else begin
            nxt_min_lo = 4'd9;
            nxt_min_hi = min_hi - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      presc_rem <= PRESC_TOP;
      min_hi    <= 4'd0;
      min_lo    <= 4'd0;
      sec_hi    <= 4'd0;
      sec_lo    <= 4'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state     <= S_IDLE;
        presc_rem <= PRESC_TOP;
        min_hi    <= clamp_digit(ld_min_hi, 4'd9);
        min_lo    <= clamp_digit(ld_min_lo, 4'd9);
        sec_hi    <= clamp_digit(ld_sec_hi, 4'd5);
        sec_lo    <= clamp_digit(ld_sec_lo, 4'd9);
      end else begin
        case (state)
          S_IDLE: begin
            if (run && !zero) state <= S_RUN;
          end
          S_RUN: begin
            // A tick in the same cycle as run falling still lands before the pause.
            if (tick) begin
              presc_rem <= PRESC_TOP;
              min_hi    <= nxt_min_hi;
              min_lo    <= nxt_min_lo;
              sec_hi    <= nxt_sec_hi;
              sec_lo    <= nxt_sec_lo;
              if (enter_exp) begin
                state <= S_EXPIRED;
                done  <= 1'b1;
              end else if (!run) begin
                state <= S_IDLE;
              end
            end else begin
              presc_rem <= presc_rem - PW'(1);
              if (!run) state <= S_IDLE;
            end
          end
          S_EXPIRED: begin
            state <= S_EXPIRED;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef COUNTDOWN_FLASH_EN
  localparam int unsigned FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FW-1:0] FLASH_TOP = FW'(FLASH_DIV - 1);

  logic [FW-1:0] flash_rem;

  // Blink starts lit on the expiry edge and is forced dark once EXPIRED is left.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      flash     <= 1'b0;
      flash_rem <= FLASH_TOP;
    end else if (enter_exp) begin
      flash     <= 1'b1;
      flash_rem <= FLASH_TOP;
    end else if ((state == S_EXPIRED) && !load) begin
      if (flash_rem == '0) begin
        flash     <= ~flash;
        flash_rem <= FLASH_TOP;
      end else begin
        flash_rem <= flash_rem - FW'(1);
      end
    end else begin
      flash     <= 1'b0;
      flash_rem <= FLASH_TOP;
    end
  end
`else
  assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_core.sv
// Scoreboard bench for countdown_core: a seconds-level reference model predicts strobes,
// a negedge monitor pops and compares them; directed scenarios plus a randomized phase.

module tb_countdown_core;
  localparam int CLK_HZ    = 4;
  localparam int FLASH_DIV = 2;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       run = 1'b0;
  logic [3:0] ld_min_hi = 4'd0, ld_min_lo = 4'd0, ld_sec_hi = 4'd0, ld_sec_lo = 4'd0;
  logic [3:0] min_hi, min_lo, sec_hi, sec_lo;
  logic       zero, tick, done, flash;
  logic [15:0] dut_digits;

  assign dut_digits = {min_hi, min_lo, sec_hi, sec_lo};

  countdown_core #(.CLK_HZ(CLK_HZ), .FLASH_DIV(FLASH_DIV)) dut (
    .CLOCK_50(clk), .RST(rst), .load(load),
    .ld_min_hi(ld_min_hi), .ld_min_lo(ld_min_lo), .ld_sec_hi(ld_sec_hi), .ld_sec_lo(ld_sec_lo),
    .run(run),
    .min_hi(min_hi), .min_lo(min_lo), .sec_hi(sec_hi), .sec_lo(sec_lo),
    .zero(zero), .tick(tick), .done(done), .flash(flash)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [15:0] digits;
  } ev_t;

  ev_t sb[$];
  int  compared = 0;
  int  mismatched = 0;

  // reference model: time held as plain seconds
  int m_state = M_IDLE;
  int m_presc = 0;
  int m_secs  = 0;
  int m_ecnt  = 0;
  bit m_done  = 1'b0;
  bit m_flash = 1'b0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m, c;
    m = s / 60;
    c = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int load_secs(input logic [3:0] a, b, c, d);
    int mh, ml, sh, sl;
    mh = (a > 9) ? 9 : int'(a);
    ml = (b > 9) ? 9 : int'(b);
    sh = (c > 5) ? 5 : int'(c);
    sl = (d > 9) ? 9 : int'(d);
    return (mh * 10 + ml) * 60 + sh * 10 + sl;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_presc = 0;
    m_secs  = 0;
    m_ecnt  = 0;
    m_done  = 1'b0;
    m_flash = 1'b0;
  endtask

  task automatic step();
    bit tk;
    @(posedge clk);
    tk = (m_state == M_RUN) && (m_presc == CLK_HZ - 1);
    m_done = 1'b0;
    if (rst) begin
      model_reset();
    end else if (load) begin
      m_state = M_IDLE;
      m_presc = 0;
      m_secs  = load_secs(ld_min_hi, ld_min_lo, ld_sec_hi, ld_sec_lo);
    end else if (m_state == M_IDLE) begin
      if (run && m_secs != 0) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (tk) begin
        m_presc = 0;
        m_secs  = m_secs - 1;
        if (m_secs == 0) begin
          m_state = M_EXP;
          m_done  = 1'b1;
          m_ecnt  = 0;
        end else if (!run) begin
          m_state = M_IDLE;
        end
      end else begin
        m_presc = m_presc + 1;
        if (!run) m_state = M_IDLE;
      end
    end
`ifdef COUNTDOWN_FLASH_EN
    if (m_state == M_EXP) begin
      m_ecnt  = m_ecnt + 1;
      m_flash = (((m_ecnt - 1) / FLASH_DIV) % 2) == 0;
    end else begin
      m_ecnt  = 0;
      m_flash = 1'b0;
    end
`else
    m_flash = 1'b0;
`endif
    #1;
    if (!rst) begin
      if ((m_state == M_RUN) && (m_presc == CLK_HZ - 1)) sb.push_back('{1'b0, to_bcd(m_secs)});
      if (m_done) sb.push_back('{1'b1, 16'h0000});
      chk("digits", dut_digits, to_bcd(m_secs));
      chk("zero", 16'(zero), 16'(m_secs == 0));
    end
  endtask

  // monitor: every cycle pops whatever strobe the model predicted for it
  always @(negedge clk) begin
    ev_t e;
    bit  has;
    if (!rst) begin
      has = (sb.size() > 0);
      if (has) e = sb.pop_front();
      chk("strobe_tick", 16'(tick), 16'(has && !e.is_done));
      chk("strobe_done", 16'(done), 16'(has && e.is_done));
      if (has) chk("strobe_digits", dut_digits, e.digits);
      chk("flash", 16'(flash), 16'(m_flash));
    end
  end

  task automatic do_load(input logic [3:0] a, b, c, d);
    load = 1'b1;
    ld_min_hi = a; ld_min_lo = b; ld_sec_hi = c; ld_sec_lo = d;
    step();
    load = 1'b0;
  endtask

  task automatic rst_mid();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_digits", dut_digits, 16'h0000);
    chk("rst_zero", 16'(zero), 16'd1);
    chk("rst_tick", 16'(tick), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_flash", 16'(flash), 16'd0);
    model_reset();
    sb.delete();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int first_tick;
    step();
    step();
    rst = 1'b0;
    chk("reset_digits", dut_digits, 16'h0000);
    chk("reset_zero", 16'(zero), 16'd1);
    chk("reset_tick", 16'(tick), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_flash", 16'(flash), 16'd0);

    // 1: 00:03 counts to expiry with ticks at 4, 8, 12 and done at 13
    do_load(4'd0, 4'd0, 4'd0, 4'd3);
    run = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t1_tick", 16'(tick), 16'(k == 4 || k == 8 || k == 12));
      chk("t1_done", 16'(done), 16'(k == 13));
    end
    chk("t1_digits", dut_digits, 16'h0000);
    run = 1'b0;

    // 2: full borrow chain, then load sanitising
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    run = 1'b1;
    repeat (4) step();
    run = 1'b0;
    step();
    chk("t2_borrow", dut_digits, 16'h0959);
    do_load(4'h9, 4'hF, 4'h7, 4'hA);
    chk("t2_sanitise", dut_digits, 16'h9959);

    // 3: pause mid-second, resume continues the partial second
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    run = 1'b1;
    repeat (6) step();
    run = 1'b0;
    repeat (10) step();
    chk("t3_hold", dut_digits, 16'h0004);
    run = 1'b1;
    first_tick = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (tick && first_tick == 0) first_tick = k;
    end
    chk("t3_resume", 16'(first_tick), 16'd2);
    run = 1'b0;
    step();

    // 4: load collides with the final tick
    do_load(4'd0, 4'd0, 4'd0, 4'd1);
    run = 1'b1;
    repeat (4) step();
    chk("t4_tick", 16'(tick), 16'd1);
    load = 1'b1;
    ld_min_hi = 4'd0; ld_min_lo = 4'd0; ld_sec_hi = 4'd3; ld_sec_lo = 4'd0;
    step();
    load = 1'b0;
    run = 1'b0;
    chk("t4_digits", dut_digits, 16'h0030);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_no_done", 16'(done), 16'd0);
      chk("t4_no_tick", 16'(tick), 16'd0);
    end

    // 5: run from 00:00 does nothing
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t5_tick", 16'(tick), 16'd0);
      chk("t5_done", 16'(done), 16'd0);
    end
    chk("t5_digits", dut_digits, 16'h0000);
    run = 1'b0;

    // 6: asynchronous reset while running at 00:02
    do_load(4'd0, 4'd0, 4'd0, 4'd3);
    run = 1'b1;
    repeat (5) step();
    chk("t6_pre", dut_digits, 16'h0002);
    rst_mid();
    run = 1'b0;
    repeat (3) step();

    // expiry blink, then load clears it
    do_load(4'd0, 4'd0, 4'd0, 4'd1);
    run = 1'b1;
    repeat (5) step();
    chk("t7_done", 16'(done), 16'd1);
    for (int e = 1; e <= 9; e++) begin
`ifdef COUNTDOWN_FLASH_EN
      chk("t7_flash", 16'(flash), 16'((((e - 1) / 2) % 2) == 0));
`else
      chk("t7_flash", 16'(flash), 16'd0);
`endif
      step();
    end
    do_load(4'd0, 4'd0, 4'd1, 4'd0);
    chk("t7_flash_clr", 16'(flash), 16'd0);
    run = 1'b0;

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          ld_min_hi = 4'($urandom_range(0, 15));
          ld_min_lo = 4'($urandom_range(0, 15));
          ld_sec_hi = 4'($urandom_range(0, 15));
          ld_sec_lo = 4'($urandom_range(0, 15));
        end else begin
          ld_min_hi = 4'd0;
          ld_min_lo = 4'd0;
          ld_sec_hi = 4'($urandom_range(0, 1));
          ld_sec_lo = 4'($urandom_range(0, 15));
        end
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) run = ~run;
      if ($urandom_range(0, 399) == 0) rst_mid();
      else step();
    end
    load = 1'b0;
    run = 1'b0;
    repeat (3) step();
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
